// File: rtl/cj_cosim_judge.sv
// Co-simulation judge: captures the program's tohost word from a snooped
// memory-write bus and runs a direct-mapped PC lookup cache on the commit
// stream, counting lookups (crednum) and hits (credhit).
module cj_cosim_judge #(
    parameter int          ENTRIES     = 16,
    parameter logic [63:0] TOHOST_ADDR = 64'h0000_0000_8000_1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic        wr_valid,
    input  logic [63:0] wr_addr,
    input  logic [63:0] wr_data,
    output logic [63:0] tohost,
    output logic [63:0] crednum,
    output logic [63:0] credhit
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 64 - IDX - 2;

    // Per-entry valid bits (control, reset) and tags (data, not reset).
    logic [ENTRIES-1:0] valid_p0;
    logic [TAG_W-1:0]   tag_p0 [ENTRIES];

    logic [IDX-1:0]     idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill;
    logic               unused_pc_lsbs;

    // Word-aligned PCs: the two byte-offset bits never take part in lookup.
    assign idx            = commit_pc[IDX+1:2];
    assign tag            = commit_pc[63:IDX+2];
    assign unused_pc_lsbs = ^commit_pc[1:0];
    assign hit            = valid_p0[idx] && (tag_p0[idx] == tag);
    assign fill           = reset && commit_valid && !hit;

    // Counters stick at all-ones instead of wrapping; since both saturate
    // identically, credhit can never overtake crednum.
    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

    // tohost capture, lookup/hit counting and valid-bit maintenance.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tohost   <= 64'd0;
            crednum  <= 64'd0;
            credhit  <= 64'd0;
            valid_p0 <= '0;
        end else begin
            if (wr_valid && (wr_addr == TOHOST_ADDR))
                tohost <= wr_data;
            if (commit_valid) begin
                crednum <= sat_inc(crednum);
                if (hit)
                    credhit <= sat_inc(credhit);
                else
                    valid_p0[idx] <= 1'b1;
            end
        end
    end

    // Tag store: a miss replaces whatever occupied the indexed entry.
    always_ff @(posedge clock) begin
        if (fill)
            tag_p0[idx] <= tag;
    end

endmodule

// File: tb/tb_cj_cosim_judge.sv
// Directed bench for cj_cosim_judge with hand-computed expectations.
module tb_cj_cosim_judge;

    localparam logic [63:0] TH = 64'h0000_0000_8000_1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        wr_valid;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;
    logic [63:0] tohost;
    logic [63:0] crednum;
    logic [63:0] credhit;

    int errors = 0;
    int checks = 0;

    cj_cosim_judge #(.ENTRIES(16), .TOHOST_ADDR(TH)) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .tohost       (tohost),
        .crednum      (crednum),
        .credhit      (credhit)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic commit(input logic [63:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        cyc();
        commit_valid = 1'b0;
    endtask

    task automatic write(input logic [63:0] a, input logic [63:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic expect_all(input string tag, input logic [63:0] th,
                              input logic [63:0] n, input logic [63:0] h);
        check({tag, ".tohost"},  tohost,  th);
        check({tag, ".crednum"}, crednum, n);
        check({tag, ".credhit"}, credhit, h);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        commit_valid = 1'b0;
        commit_pc    = 64'd0;
        wr_valid     = 1'b0;
        wr_addr      = 64'd0;
        wr_data      = 64'd0;

        // Reset state, with activity on the inputs that must be ignored.
        commit_valid = 1'b1;
        commit_pc    = 64'h8000_0000;
        wr_valid     = 1'b1;
        wr_addr      = TH;
        wr_data      = 64'h77;
        cyc();
        cyc();
        commit_valid = 1'b0;
        wr_valid     = 1'b0;
        expect_all("reset", 64'd0, 64'd0, 64'd0);
        reset = 1'b1;

        commit(64'h8000_0000);
        expect_all("first_miss", 64'd0, 64'd1, 64'd0);

        // tohost capture
        write(TH, 64'd1);
        check("tohost_set", tohost, 64'd1);
        write(TH + 64'd8, 64'd5);
        check("tohost_other_addr", tohost, 64'd1);
        wr_valid = 1'b0; wr_addr = TH; wr_data = 64'd9;
        cyc();
        check("tohost_no_valid", tohost, 64'd1);
        write(TH, 64'd0);
        check("tohost_clear", tohost, 64'd0);

        // Reset after activity, then repeated hits.
        do_reset();
        expect_all("reset2", 64'd0, 64'd0, 64'd0);
        commit(64'h8000_0000);
        commit(64'h8000_0000);
        expect_all("rep2", 64'd0, 64'd2, 64'd1);
        commit(64'h8000_0000);
        expect_all("rep3", 64'd0, 64'd3, 64'd2);

        // Same-index conflict evicts.
        do_reset();
        commit(64'h8000_0000);
        commit(64'h8000_0040);
        commit(64'h8000_0000);
        expect_all("conflict", 64'd0, 64'd3, 64'd0);

        // Distinct indices coexist.
        do_reset();
        commit(64'h8000_0000);
        commit(64'h8000_0004);
        commit(64'h8000_0000);
        commit(64'h8000_0004);
        expect_all("distinct", 64'd0, 64'd4, 64'd2);

        // Byte-offset bits are ignored.
        commit(64'h8000_0003);
        expect_all("lsb_ignored", 64'd0, 64'd5, 64'd3);

        // No commit: counters hold.
        commit_pc = 64'h8000_0000;
        cyc();
        expect_all("idle", 64'd0, 64'd5, 64'd3);

        // High tag bits differ: miss, and replaces the entry.
        commit(64'h0000_0001_8000_0000);
        expect_all("hi_tag_miss", 64'd0, 64'd6, 64'd3);
        commit(64'h8000_0000);
        expect_all("hi_tag_evict", 64'd0, 64'd7, 64'd3);

        // Simultaneous commit (hit) and tohost write.
        commit_valid = 1'b1;
        commit_pc    = 64'h8000_0000;
        wr_valid     = 1'b1;
        wr_addr      = TH;
        wr_data      = 64'd3;
        cyc();
        commit_valid = 1'b0;
        wr_valid     = 1'b0;
        expect_all("simul", 64'd3, 64'd8, 64'd4);

        // Single-edge reset clears everything, including cache contents.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        expect_all("reset3", 64'd0, 64'd0, 64'd0);
        commit(64'h8000_0000);
        expect_all("post_reset_miss", 64'd0, 64'd1, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cj_cosim_judge.md
Name: cj_cosim_judge

Overview:
- Co-simulation judge that sits beside the SoC test harness in simulation.
- Latches the program's tohost word from a snooped memory-write bus; the bench ends or recycles a round when tohost bit0 is set.
- Runs a small direct-mapped PC lookup cache on the commit stream and exposes lookup and hit counters (crednum, credhit) for the end-of-run hit-rate report.

Parameters:
- ENTRIES, 16, number of PC cache entries; power of two, minimum 2.
- TOHOST_ADDR, 64'h0000_0000_8000_1000, byte address of the tohost word.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-low.
- commit_valid  input  1  one instruction retires this cycle.
- commit_pc  input  64  PC of the retiring instruction.
- wr_valid  input  1  memory write beat valid.
- wr_addr  input  64  write byte address.
- wr_data  input  64  write data.
- tohost  output  64  last value written to TOHOST_ADDR.
- crednum  output  64  number of PC cache lookups.
- credhit  output  64  number of PC cache hits.
- The harness drives all snoop inputs. When they are unconnected they are tied to 0, which leaves the outputs at 0.

Behaviour:
- Reset: sampled on rising clock; when reset==0 at an edge:
  - tohost <= 0, crednum <= 0, credhit <= 0.
  - All cache valid bits cleared.
  - Inputs are ignored that cycle. Reset asserted mid-operation discards all state the same way.
- tohost capture:
  - On an edge with reset==1, wr_valid==1 and wr_addr==TOHOST_ADDR (full 64-bit compare): tohost <= wr_data, registered with 1-cycle latency.
  - Writes to any other address are ignored.
  - tohost holds its value until the next matching write; a write of 0 clears it.
- PC cache geometry:
  - IDX = log2(ENTRIES).
  - index = commit_pc[IDX+1:2].
  - tag = commit_pc[63:IDX+2].
  - commit_pc[1:0] is ignored.
  - Storage per entry: valid bit plus tag.
- Lookup, on an edge with reset==1 and commit_valid==1:
  - Hit = entry[index].valid && entry[index].tag==tag, evaluated on pre-edge state.
  - crednum increments by 1.
  - credhit increments by 1 if hit.
  - On a miss: entry[index] <= {valid=1, tag}; the previous occupant is replaced.
  - On a hit the entry is unchanged.
  - Two consecutive commits of the same PC: the first misses and fills, the second hits (the fill is visible the next cycle).
- Counters:
  - 64-bit, saturating at all-ones (no wrap).
  - credhit <= crednum holds at all times.
- Simultaneous tohost write and commit in one cycle: both are processed independently.
- No combinational input-to-output paths; all outputs are registers.

Test Plan:
- Reset: hold reset=0 for 2 edges after arbitrary activity -> tohost=0, crednum=0, credhit=0; the first commit afterwards misses.
- tohost: write 1 to TOHOST_ADDR -> tohost==1 one edge later. Write 5 to TOHOST_ADDR+8 -> tohost stays 1. Write 0 to TOHOST_ADDR -> tohost==0.
- Repeat hits: commit PC 0x80000000 three times -> crednum=3, credhit=2.
- Conflict: commit 0x80000000, then 0x80000040 (same index with ENTRIES=16), then 0x80000000 -> crednum=3, credhit=0.
- Distinct indices: commit 0x80000000, 0x80000004, 0x80000000, 0x80000004 -> crednum=4, credhit=2.
- Simultaneous events: same cycle commit 0x80000000 plus tohost write 0x3 -> tohost=3 and crednum increments. Assert reset on the next edge -> all outputs 0.
